fifo_sync_lvl: RTL and testbench
================================

// Module: fifo_sync_lvl
// PURPOSE
//  Single-clock parametrised FIFO; successor to the dual-clock fifo1 for paths
//  that need no clock crossing. Adds occupancy count, programmable almost-full/
//  almost-empty thresholds, sticky overflow/underflow flags and a synchronous flush.
//  Sits between a producer and consumer in the same clock domain.
// PARAMETERS
//  DATASIZE    8   data word width, bits
//  ADDRSIZE    4   address width; DEPTH = 2**ADDRSIZE words
//  AFULL_THR   12  walmost_full asserts when level >= AFULL_THR (legal 1..DEPTH)
//  AEMPTY_THR  2   ralmost_empty asserts when level <= AEMPTY_THR (legal 0..DEPTH-1)
// PORTS
//  clk            in   1           single clock, all logic on rising edge
//  rst_n          in   1           asynchronous reset, active-low
//  clr            in   1           synchronous flush, active-high
//  winc           in   1           write request
//  wdata          in   DATASIZE    write data
//  rinc           in   1           read request
//  rdata          out  DATASIZE    read data
//  wfull          out  1           FIFO full
//  rempty         out  1           FIFO empty
//  walmost_full   out  1           level >= AFULL_THR
//  ralmost_empty  out  1           level <= AEMPTY_THR
//  level          out  ADDRSIZE+1  words stored, 0..DEPTH
//  overflow       out  1           sticky: write attempted while full
//  underflow      out  1           sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (rst_n=0, async): pointers=0, level=0, rempty=1, wfull=0,
//    ralmost_empty=1, walmost_full=0, overflow=0, underflow=0, rdata=0.
//    Memory array not reset. Reset mid-operation discards all contents.
//  - Pointers wptr/rptr binary, ADDRSIZE+1 bits; MSB distinguishes full from
//    empty on wrap. level = wptr - rptr (mod 2**(ADDRSIZE+1)).
//  - Write accepted iff winc & ~wfull: mem[wptr[ADDRSIZE-1:0]] <= wdata, wptr+1.
//  - Read accepted iff rinc & ~rempty: rptr+1.
//  - Simultaneous accepted read+write: level unchanged, flags unchanged.
//  - Full with winc&rinc: read accepted, write rejected, overflow set.
//  - Empty with winc&rinc: write accepted, read rejected, underflow set.
//  - All flags and level registered, computed from next-state level, so they
//    are valid the cycle after the causing edge: wfull=(level_nx==DEPTH),
//    rempty=(level_nx==0), thresholds compare level_nx.
//  - overflow/underflow: set on rejected request, held until rst_n or clr.
//  - clr: next edge forces pointers, level, flags, sticky bits to reset values;
//    clr beats winc/rinc in the same cycle (neither accepted, no sticky set).
//    rdata retains its value on clr.
//  - Illegal AFULL_THR/AEMPTY_THR: elaboration-time $error in simulation.
// CONFIGURATION
//  FIFO_FWFT_EN defined: first-word-fall-through. rdata = mem[rptr] combinational,
//   valid whenever rempty=0; rinc acknowledges/pops the presented word. Write to
//   empty FIFO: word on rdata and rempty=0 one cycle after write edge.
//  FIFO_FWFT_EN undefined: registered read. On accepted read rdata <= mem[rptr]
//   at that edge (1-cycle latency); rdata holds otherwise.
// TESTING (DATASIZE=8, ADDRSIZE=4, AFULL_THR=12, AEMPTY_THR=2; both macro settings)
//  1 Reset then write 8'h00..8'h0F on 16 consecutive cycles -> level 1..16,
//    walmost_full rises after 12th write, wfull=1 after 16th, rempty=0 after 1st.
//  2 Full, winc=1 with 8'hAA, rinc=0 -> level stays 16, overflow=1 sticky, 8'hAA
//    never read back; drain 16 reads -> data 8'h00..8'h0F in order, rempty=1.
//  3 Empty, rinc=1 -> underflow=1, level 0; then clr for 1 cycle -> underflow=0.
//  4 Level 8, winc=rinc=1 for 40 cycles (pointer wrap twice) -> level fixed at 8,
//    read data sequence equals write sequence delayed by 8 words.
//  5 Full, winc=rinc=1 same cycle -> read accepted, overflow=1, level 15.
//  6 Level 5, assert clr with winc=1 -> next cycle level 0, rempty=1,
//    ralmost_empty=1; rst_n pulse mid-stream -> all outputs at reset values.

Source files
------------

// File: rtl/fifo_sync_lvl.sv
// Single-clock FIFO with occupancy level, almost-full/almost-empty thresholds,
// sticky overflow/underflow and synchronous flush. Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_sync_lvl #(
  parameter int DATASIZE   = 8,
  parameter int ADDRSIZE   = 4,
  parameter int AFULL_THR  = 12,
  parameter int AEMPTY_THR = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                wfull,
  output logic                rempty,
  output logic                walmost_full,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   level,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] LP_DEPTH  = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0] LP_AFULL  = (ADDRSIZE+1)'(AFULL_THR);
  localparam logic [ADDRSIZE:0] LP_AEMPTY = (ADDRSIZE+1)'(AEMPTY_THR);
  localparam logic [ADDRSIZE:0] LP_ONE    = (ADDRSIZE+1)'(1);

  if (AFULL_THR < 1 || AFULL_THR > DEPTH) begin : g_bad_afull
    $error("fifo_sync_lvl: AFULL_THR=%0d outside 1..%0d", AFULL_THR, DEPTH);
  end
  if (AEMPTY_THR < 0 || AEMPTY_THR > DEPTH - 1) begin : g_bad_aempty
    $error("fifo_sync_lvl: AEMPTY_THR=%0d outside 0..%0d", AEMPTY_THR, DEPTH - 1);
  end

  logic [DATASIZE-1:0] r_mem [DEPTH];
  logic [ADDRSIZE:0]   r_wptr, r_rptr, r_level;
  logic                r_wfull, r_rempty, r_afull, r_aempty, r_ovf, r_udf;

  logic                w_wr_acc, w_rd_acc, w_wr_rej, w_rd_rej;
  logic [ADDRSIZE:0]   w_wptr_nx, w_rptr_nx, w_level_nx;

  // Flush dominates: while clr is high no request is accepted or flagged.
  assign w_wr_acc = winc & ~r_wfull  & ~clr;
  assign w_rd_acc = rinc & ~r_rempty & ~clr;
  assign w_wr_rej = winc &  r_wfull  & ~clr;
  assign w_rd_rej = rinc &  r_rempty & ~clr;

  assign w_wptr_nx  = clr ? '0 : (w_wr_acc ? r_wptr + LP_ONE : r_wptr);
  assign w_rptr_nx  = clr ? '0 : (w_rd_acc ? r_rptr + LP_ONE : r_rptr);
  assign w_level_nx = w_wptr_nx - w_rptr_nx;

  // NOTE: storage has no reset so it maps onto plain RAM; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr[ADDRSIZE-1:0]] <= wdata;
  end

  // NOTE: all state updates are non-blocking so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_wfull  <= 1'b0;
      r_rempty <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_wptr   <= w_wptr_nx;
      r_rptr   <= w_rptr_nx;
      r_level  <= w_level_nx;
      r_wfull  <= (w_level_nx == LP_DEPTH);
      r_rempty <= (w_level_nx == '0);
      r_afull  <= (w_level_nx >= LP_AFULL);
      r_aempty <= (w_level_nx <= LP_AEMPTY);
      r_ovf    <= clr ? 1'b0 : (r_ovf | w_wr_rej);
      r_udf    <= clr ? 1'b0 : (r_udf | w_rd_rej);
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented directly; forced to zero while empty so reset reads zero.
  assign rdata = r_rempty ? '0 : r_mem[r_rptr[ADDRSIZE-1:0]];
`else
  logic [DATASIZE-1:0] r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_rdata <= '0;
    else if (w_rd_acc) r_rdata <= r_mem[r_rptr[ADDRSIZE-1:0]];
  end

  assign rdata = r_rdata;
`endif

  assign wfull         = r_wfull;
  assign rempty        = r_rempty;
  assign walmost_full  = r_afull;
  assign ralmost_empty = r_aempty;
  assign level         = r_level;
  assign overflow      = r_ovf;
  assign underflow     = r_udf;

endmodule

// File: tb/tb_fifo_sync_lvl.sv
// Directed bench for fifo_sync_lvl (DATASIZE=8, ADDRSIZE=4, AFULL_THR=12, AEMPTY_THR=2);
// read-data expectations follow the FIFO_FWFT_EN setting of the build.
module tb_fifo_sync_lvl;

  logic       clk = 1'b0;
  logic       rst_n, clr, winc, rinc;
  logic [7:0] wdata, rdata;
  logic       wfull, rempty, walmost_full, ralmost_empty, overflow, underflow;
  logic [4:0] level;

  int n_checks = 0;
  int n_errs   = 0;

  fifo_sync_lvl #(.DATASIZE(8), .ADDRSIZE(4), .AFULL_THR(12), .AEMPTY_THR(2)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .winc(winc), .wdata(wdata), .rinc(rinc),
    .rdata(rdata), .wfull(wfull), .rempty(rempty), .walmost_full(walmost_full),
    .ralmost_empty(ralmost_empty), .level(level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       winc;
    logic [7:0] wdata;
    logic       rinc;
    logic       clr;
    logic [4:0] level;
    logic       wfull, rempty, afull, aempty, ovf, udf;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input logic [4:0] lv, input logic wf, input logic re,
                             input logic af, input logic ae, input logic ov, input logic un);
    check({tag, ".level"},         level,         lv);
    check({tag, ".wfull"},         wfull,         wf);
    check({tag, ".rempty"},        rempty,        re);
    check({tag, ".walmost_full"},  walmost_full,  af);
    check({tag, ".ralmost_empty"}, ralmost_empty, ae);
    check({tag, ".overflow"},      overflow,      ov);
    check({tag, ".underflow"},     underflow,     un);
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    winc = w; wdata = d; rinc = r; clr = c;
    @(posedge clk); #1;
    winc = 1'b0; rinc = 1'b0; clr = 1'b0;
  endtask

  // Pop one word, optionally writing in the same cycle, and check the word read.
  task automatic pop_check(input string name, input logic [7:0] exp, input logic w, input logic [7:0] d);
`ifdef FIFO_FWFT_EN
    check(name, rdata, exp);
    cyc(w, d, 1'b1, 1'b0);
`else
    cyc(w, d, 1'b1, 1'b0);
    check(name, rdata, exp);
`endif
  endtask

  function automatic logic [7:0] seq4(input int n);
    return 8'(n * 7 + 3);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("reset.rdata", rdata, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1 and the overflow write of test 2 as a vector table.
    for (int i = 0; i < 16; i++) begin
      vecs[i].winc   = 1'b1;
      vecs[i].wdata  = 8'(i);
      vecs[i].rinc   = 1'b0;
      vecs[i].clr    = 1'b0;
      vecs[i].level  = 5'(i + 1);
      vecs[i].wfull  = (i == 15);
      vecs[i].rempty = 1'b0;
      vecs[i].afull  = (i + 1 >= 12);
      vecs[i].aempty = (i + 1 <= 2);
      vecs[i].ovf    = 1'b0;
      vecs[i].udf    = 1'b0;
    end
    vecs[16] = '{winc: 1'b1, wdata: 8'hAA, rinc: 1'b0, clr: 1'b0, level: 5'd16, wfull: 1'b1,
                 rempty: 1'b0, afull: 1'b1, aempty: 1'b0, ovf: 1'b1, udf: 1'b0};
    for (int i = 0; i < 17; i++) begin
      cyc(vecs[i].winc, vecs[i].wdata, vecs[i].rinc, vecs[i].clr);
      check_state($sformatf("vec%0d", i), vecs[i].level, vecs[i].wfull, vecs[i].rempty,
                  vecs[i].afull, vecs[i].aempty, vecs[i].ovf, vecs[i].udf);
    end

    // Test 2: drain returns 00..0F, never AA; overflow stays sticky.
    for (int i = 0; i < 16; i++) begin
      pop_check($sformatf("drain%0d.rdata", i), 8'(i), 1'b0, 8'h00);
      check($sformatf("drain%0d.level", i), level, 5'(15 - i));
    end
    check_state("drained", 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    // Test 3: underflow on empty read, cleared by clr; registered rdata survives clr.
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check_state("underflow", 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check_state("clr1", 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef FIFO_FWFT_EN
    check("clr1.rdata", rdata, 8'h00);
`else
    check("clr1.rdata", rdata, 8'h0F);
`endif

    // Test 4: level 8, 40 simultaneous read/write cycles, pointers wrap.
    for (int n = 0; n < 8; n++) cyc(1'b1, seq4(n), 1'b0, 1'b0);
    check("fill8.level", level, 5'd8);
    for (int k = 0; k < 40; k++) begin
      pop_check($sformatf("stream%0d.rdata", k), seq4(k), 1'b1, seq4(k + 8));
      check($sformatf("stream%0d.level", k), level, 5'd8);
    end
    check_state("stream.end", 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Test 5: full with winc&rinc -> read accepted, write rejected.
    for (int n = 0; n < 16; n++) cyc(1'b1, 8'(8'h40 + n), 1'b0, 1'b0);
    check("fill16.wfull", wfull, 1'b1);
    pop_check("fullrw.rdata", 8'h40, 1'b1, 8'hBB);
    check_state("fullrw", 5'd15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Test 6: clr beats winc, clr beats rinc (no underflow), then async reset mid-stream.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) cyc(1'b1, 8'(8'h60 + n), 1'b0, 1'b0);
    check_state("lvl5", 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h99, 1'b0, 1'b1);
    check_state("clrw", 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    check("clrr.underflow", underflow, 1'b0);
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    cyc(1'b1, 8'h56, 1'b0, 1'b0);
    cyc(1'b1, 8'h57, 1'b0, 1'b0);
    pop_check("prerst.rdata", 8'h55, 1'b0, 8'h00);
    check("prerst.level", level, 5'd2);
    winc = 1'b1; wdata = 8'h77;
    #2 rst_n = 1'b0;
    #1;
    winc = 1'b0;
    check_state("midrst", 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("midrst.rdata", rdata, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_state("postrst", 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
